pmissile_controller: RTL

Frame-rate sequencer for the player's single missile. It turns the player's fire request into launches, moves the missile up one step per frame, and retires it on an enemy hit or at the top bound. After each missile it enforces an explosion hold and a refire cooldown. It sits between the player ship logic (fire request, ship X) and the renderer and collision logic (missile position, active flag, hit pulse).

---
 rtl/invaders_pkg.sv | 25 ++
 rtl/pmissile_controller_if.sv | 25 ++
 rtl/pmissile_controller_frame_counter.sv | 29 ++
 rtl/pmissile_controller.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/invaders_pkg.sv
// Shared definitions for the invaders game blocks: missile FSM states, screen
// geometry, keycodes and small arithmetic helpers.
package invaders_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLYING   = 2'd1,
        EXPLODE  = 2'd2,
        COOLDOWN = 2'd3
    } pmissile_state_t;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned PLAYER_Y = 448;

    localparam logic [7:0] KEY_A     = 8'd4;
    localparam logic [7:0] KEY_D     = 8'd7;
    localparam logic [7:0] KEY_SPACE = 8'd44;

    // Statistics counters stick at full scale instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/pmissile_controller_if.sv
// Missile controller bus: ship-side requests in, renderer/collision view out.
interface pmissile_controller_if;

    logic       pmissile_create;
    logic [9:0] x_pos;
    logic       game_active;
    logic       enemy_hit;
    logic       missile_active;
    logic [9:0] missile_x;
    logic [9:0] missile_y;
    logic       explode;
    logic       hit_pulse;
    logic [7:0] shots_fired;

    modport master (
        output pmissile_create, x_pos, game_active, enemy_hit,
        input  missile_active, missile_x, missile_y, explode, hit_pulse, shots_fired
    );

    modport slave (
        input  pmissile_create, x_pos, game_active, enemy_hit,
        output missile_active, missile_x, missile_y, explode, hit_pulse, shots_fired
    );

endinterface

// File: rtl/pmissile_controller_frame_counter.sv
// Loadable frame up-counter with a terminal-count compare; load wins over enable.
module frame_counter #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    // NOTE: sequential state is written only with non-blocking assignments so
    // every reader sees the pre-edge value regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == terminal);

endmodule

// File: rtl/pmissile_controller.sv
// Player missile sequencer, stepped once per frame on vsync: launch on a fire
// edge, climb, retire on hit or top bound, then explosion hold and cooldown.
module pmissile_controller
    import invaders_pkg::*;
#(
    parameter int unsigned SPEED           = 4,
    parameter int unsigned SPAWN_Y         = 440,
    parameter int unsigned TOP_Y           = 8,
    parameter int unsigned SHIP_HALF_W     = 16,
    parameter int unsigned EXPLODE_FRAMES  = 12,
    parameter int unsigned COOLDOWN_FRAMES = 16
) (
    input  logic                  vsync,
    input  logic                  reset,
    pmissile_controller_if.slave  bus
);

    localparam int unsigned CNT_W      = 5;
    localparam logic [9:0]  SPEED_V    = 10'(SPEED);
    localparam logic [9:0]  SPAWN_V    = 10'(SPAWN_Y);
    localparam logic [9:0]  HALF_W_V   = 10'(SHIP_HALF_W);
    localparam logic [9:0]  RETIRE_Y   = 10'(TOP_Y + SPEED);
    localparam logic [CNT_W-1:0] EXPLODE_TC  = CNT_W'(EXPLODE_FRAMES - 1);
    localparam logic [CNT_W-1:0] COOLDOWN_TC = CNT_W'(COOLDOWN_FRAMES - 1);

    pmissile_state_t  state;
    logic             fire_prev;
    logic             fire_edge;
    logic             missile_active;
    logic [9:0]       missile_x;
    logic [9:0]       missile_y;
    logic             explode;
    logic             hit_pulse;
    logic [7:0]       shots_fired;

    logic             cnt_load;
    logic             cnt_enable;
    logic [CNT_W-1:0] cnt_terminal;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_done;

    assign fire_edge = bus.pmissile_create & ~fire_prev;

    // The counter only runs while holding in EXPLODE/COOLDOWN; any other state,
    // an abort, or reaching terminal count parks it back at zero.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_load     = 1'b1;
        cnt_enable   = 1'b0;
        cnt_terminal = COOLDOWN_TC;
        unique case (state)
            EXPLODE: begin
                cnt_terminal = EXPLODE_TC;
                cnt_enable   = 1'b1;
                cnt_load     = ~bus.game_active | cnt_done;
            end
            COOLDOWN: begin
                cnt_enable   = 1'b1;
                cnt_load     = ~bus.game_active | cnt_done;
            end
            default: ;
        endcase
    end

    frame_counter #(
        .WIDTH (CNT_W)
    ) u_frame_counter (
        .clk        (vsync),
        .reset      (reset),
        .load       (cnt_load),
        .load_value ('0),
        .enable     (cnt_enable),
        .terminal   (cnt_terminal),
        .count      (cnt_value),
        .done       (cnt_done)
    );

    always_ff @(posedge vsync) begin
        if (reset) begin
            state          <= IDLE;
            fire_prev      <= 1'b0;
            missile_active <= 1'b0;
            missile_x      <= '0;
            missile_y      <= '0;
            explode        <= 1'b0;
            hit_pulse      <= 1'b0;
            shots_fired    <= '0;
        end else begin
            fire_prev <= bus.pmissile_create;
            hit_pulse <= 1'b0;

            // Dropping play aborts from any state; position and tally are kept.
            if (!bus.game_active) begin
                state          <= IDLE;
                missile_active <= 1'b0;
                explode        <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (fire_edge) begin
                            state          <= FLYING;
                            missile_x      <= bus.x_pos + HALF_W_V;
                            missile_y      <= SPAWN_V;
                            missile_active <= 1'b1;
                            shots_fired    <= sat_inc8(shots_fired);
                        end
                    end
                    FLYING: begin
                        if (bus.enemy_hit) begin
                            state          <= EXPLODE;
                            missile_active <= 1'b0;
                            explode        <= 1'b1;
                            hit_pulse      <= 1'b1;
                        end else if (missile_y < RETIRE_Y) begin
                            state          <= COOLDOWN;
                            missile_active <= 1'b0;
                        end else begin
                            missile_y      <= missile_y - SPEED_V;
                        end
                    end
                    EXPLODE: begin
                        if (cnt_done) begin
                            state   <= COOLDOWN;
                            explode <= 1'b0;
                        end
                    end
                    COOLDOWN: begin
                        if (cnt_done) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.missile_active = missile_active;
    assign bus.missile_x      = missile_x;
    assign bus.missile_y      = missile_y;
    assign bus.explode        = explode;
    assign bus.hit_pulse      = hit_pulse;
    assign bus.shots_fired    = shots_fired;

endmodule
